pipeline_hazard_ctrl: RTL
=========================

# pipeline_hazard_ctrl

Hazard and sequencing controller for the 5-stage RISC-V pipeline. It keeps shadow copies of the destination and source fields as instructions move through EX, MEM and WB. From these it drives:
- stall and flush signals for the PC, IF/ID and ID/EX registers;
- ALU operand forwarding selects for the instruction in EX;
- a full-pipeline freeze while data memory is not ready.

It sits beside the decoder and consumes its per-instruction register-use and memory-class outputs.

## Interface
- REG_AW, 5, register address width
- MEM_WAIT_MAX, 15, number of consecutive frozen cycles before mem_err is raised
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset; one clock; reset is synchronous and active-low
- id_valid  in  1  ID holds a real instruction
- id_rs1, id_rs2  in  REG_AW  ID source registers
- id_use_rs1, id_use_rs2  in  1  ID instruction reads that source
- id_rd  in  REG_AW  ID destination register
- id_regwen  in  1  ID instruction writes rd
- id_is_load  in  1  decoder memory code is a load
- id_is_store  in  1  decoder memory code is a store
- ex_redirect  in  1  EX resolved a taken branch or a jump
- dmem_ready  in  1  data memory finishes the MEM-stage access this cycle
- pc_stall, if_id_stall  out  1  hold the PC and the IF/ID register
- if_id_flush, id_ex_flush  out  1  insert a bubble into that register
- fwd_a_sel, fwd_b_sel  out  2  operand source: 00 register file, 01 EX/MEM ALU result, 10 WB data
- mem_err  out  1  sticky memory-timeout flag
- stall_cycles  out  32  saturating count of stalled cycles

## Operation
- **Shadow stages.** EX, MEM and WB each hold {valid, rd, regwen, is_load, is_mem}; EX also holds rs1 and rs2.
  - They advance only when not frozen: wb<=mem, mem<=ex, ex<=id.
  - If id_ex_flush is asserted, ex is loaded with zeros instead of id.
- **Producer rule.** A stage produces register r only when valid && regwen && rd==r && r!=0.
- **Load-use hazard.**
  - Condition: EX is a load producer of an ID source that is in use, and id_valid=1.
  - Response for one cycle: pc_stall=1, if_id_stall=1, id_ex_flush=1.
- **Redirect.**
  - ex_redirect=1 while not frozen gives if_id_flush=1 and id_ex_flush=1, with pc_stall=0 and if_id_stall=0.
  - Redirect takes priority over a load-use stall in the same cycle.
- **Memory wait.** The pipeline is frozen when MEM is valid && is_mem && dmem_ready=0.
  - pc_stall=1 and if_id_stall=1.
  - Both flushes are 0; redirect is ignored (it is re-seen after the freeze because EX is held).
  - Shadow registers hold.
- **Forwarding** (A uses ex rs1, B uses ex rs2).
  - 01 when MEM is a non-load producer.
  - Otherwise 10 when WB is a producer.
  - Otherwise 00.
  - MEM has priority. A load in MEM never forwards; the load-use stall guarantees that case cannot occur.
- **FSM states.**
  - RUN: normal operation. Goes to WAIT when a freeze starts.
  - WAIT: frozen, wait_cnt increments. Returns to RUN when dmem_ready=1. Goes to ERR when wait_cnt reaches MEM_WAIT_MAX.
  - ERR: mem_err=1, pc_stall=1 and if_id_stall=1, all else held. Left only by reset.
- **stall_cycles** increments in every cycle where pc_stall=1 and saturates at 0xFFFFFFFF.

## Timing
- **Reset.**
  - All outputs are 0 and fwd sels are 00.
  - Shadow stages are invalid, state is RUN, wait_cnt=0, mem_err=0.
  - Reset mid-freeze or in ERR returns to RUN next cycle.
- **Combinational outputs.** Stall, flush and fwd outputs are combinational from the registered shadow state plus ID inputs, ex_redirect and dmem_ready. There are no input-to-output flops.
- **Load-use latency.** Exactly one bubble: the load is in EX at t, in MEM at t+1 and in WB at t+2; the consumer reaches EX at t+2 with sel=10.
- **Memory wait count.** The freeze lasts exactly as many cycles as dmem_ready is low. The first ready cycle releases the freeze, and the shadow stages advance on that edge.
- **Watchdog boundary.** wait_cnt resets on leaving WAIT. ERR is entered on the edge where wait_cnt==MEM_WAIT_MAX−1 and dmem_ready is still 0.
- **x0.** Never stalls and never forwards.

## Configuration
- FORWARDING_EN defined: behaviour as above.
- FORWARDING_EN undefined:
  - fwd_a_sel and fwd_b_sel are tied to 00.
  - A stall (pc_stall, if_id_stall, id_ex_flush) is raised whenever EX or MEM is a producer of an in-use ID source. This subsumes load-use.
  - WB needs no stall, because the register file returns the WB write data to same-cycle ID reads.

## Structure
- Package hazard_pkg:
  - fwd_sel_t (FWD_RF=00, FWD_MEM=01, FWD_WB=10);
  - state_t (RUN, WAIT, ERR);
  - stage_t struct for the shadow stages.
- Sub-module hazard_fwd_sel: computes one forwarding select from the source register and the MEM/WB stage records; instantiated twice (A and B).

## Test plan
- **Load-use.** lw x5 in EX, add x6,x5,x1 in ID → one cycle with pc_stall=if_id_stall=id_ex_flush=1; two cycles later fwd_a_sel=10.
- **ALU back-to-back.** add x3 followed by sub x4,x3,x3 → no stall, fwd_a_sel=fwd_b_sel=01; with FORWARDING_EN undefined → two stall cycles, sels 00.
- **Redirect plus load-use in the same cycle.** → if_id_flush=id_ex_flush=1, pc_stall=0.
- **Store in MEM, dmem_ready low for 3 cycles.** → pc_stall high for exactly 3 cycles, shadows unchanged, stall_cycles +3.
- **dmem_ready held low for 15 cycles (MEM_WAIT_MAX=15).** → mem_err=1 and stays set; rst_n low for one edge clears it and all outputs return to 0.
- **rd=x0 producer with a consumer of x0.** → no stall, sels 00.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and helpers for the pipeline hazard controller.
package hazard_pkg;

    localparam int unsigned REG_AW = 5;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_t;

    typedef enum logic [1:0] {
        RUN  = 2'b00,
        WAIT = 2'b01,
        ERR  = 2'b10
    } state_t;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              regwen;
        logic              is_load;
        logic              is_mem;
    } stage_t;

    // x0 is hardwired, so it is never a real producer.
    function automatic logic produces(stage_t s, logic [REG_AW-1:0] r);
        return s.valid && s.regwen && (s.rd == r) && (r != '0);
    endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// Forwarding select for one EX operand; MEM beats WB and a load in MEM never forwards.
module hazard_fwd_sel
    import hazard_pkg::*;
(
    input  logic [REG_AW-1:0] rs,
    input  stage_t            mem,
    input  stage_t            wb,
    output fwd_sel_t          sel
);

    logic unused_bits;
    assign unused_bits = ^{mem.is_mem, wb.is_load, wb.is_mem};

    always_comb begin
        sel = FWD_RF;
        if (produces(mem, rs) && !mem.is_load) begin
            sel = FWD_MEM;
        end else if (produces(wb, rs)) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/forwarding controller for the 5-stage pipeline with a data-memory watchdog.
// Define FORWARDING_EN for EX operand bypass; otherwise dependent instructions interlock.
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned MEM_WAIT_MAX = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_regwen,
    input  logic              id_is_load,
    input  logic              id_is_store,
    input  logic              ex_redirect,
    input  logic              dmem_ready,
    output logic              pc_stall,
    output logic              if_id_stall,
    output logic              if_id_flush,
    output logic              id_ex_flush,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic              mem_err,
    output logic [31:0]       stall_cycles
);

    localparam int unsigned     CntW     = $clog2(MEM_WAIT_MAX + 1);
    localparam logic [CntW-1:0] WaitLast = CntW'(MEM_WAIT_MAX - 1);

    stage_t            id_stage, ex_q, mem_q, wb_q;
    logic [REG_AW-1:0] ex_rs1_q, ex_rs2_q;
    state_t            state_q, state_d;
    logic [CntW-1:0]   wait_cnt_q, wait_cnt_d;
    logic [31:0]       stall_cnt_q;
    logic              mem_wait, frozen, ex_hit, mem_hit, hazard;
    fwd_sel_t          sel_a, sel_b;

    assign id_stage = '{valid: id_valid, rd: id_rd, regwen: id_regwen, is_load: id_is_load,
                        is_mem: id_is_load | id_is_store};

    assign mem_wait = mem_q.valid && mem_q.is_mem && !dmem_ready;
    assign frozen   = mem_wait || (state_q == ERR);

    assign ex_hit  = (id_use_rs1 && produces(ex_q, id_rs1)) ||
                     (id_use_rs2 && produces(ex_q, id_rs2));
    assign mem_hit = (id_use_rs1 && produces(mem_q, id_rs1)) ||
                     (id_use_rs2 && produces(mem_q, id_rs2));

    hazard_fwd_sel u_fwd_a (.rs(ex_rs1_q), .mem(mem_q), .wb(wb_q), .sel(sel_a));
    hazard_fwd_sel u_fwd_b (.rs(ex_rs2_q), .mem(mem_q), .wb(wb_q), .sel(sel_b));

`ifdef FORWARDING_EN
    logic unused_hit;
    assign unused_hit = mem_hit;
    assign hazard     = id_valid && ex_q.is_load && ex_hit;
    assign fwd_a_sel  = sel_a;
    assign fwd_b_sel  = sel_b;
`else
    // WB needs no interlock: the register file bypasses its write data to same-cycle reads.
    logic unused_sel;
    assign unused_sel = ^{sel_a, sel_b};
    assign hazard     = id_valid && (ex_hit || mem_hit);
    assign fwd_a_sel  = FWD_RF;
    assign fwd_b_sel  = FWD_RF;
`endif

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        unique case (state_q)
            RUN, WAIT: begin
                if (!mem_wait) begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == WaitLast) begin
                    state_d = ERR;
                end else begin
                    state_d    = WAIT;
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            ERR:     state_d = ERR;
            default: state_d = RUN;
        endcase
    end

    // Freeze dominates; a redirect outranks a load-use stall.
    always_comb begin
        pc_stall    = 1'b0;
        if_id_stall = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        if (frozen) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
        end else if (ex_redirect) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (hazard) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_flush = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            ex_rs1_q    <= '0;
            ex_rs2_q    <= '0;
            state_q     <= RUN;
            wait_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            if (pc_stall && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (!frozen) begin
                wb_q  <= mem_q;
                mem_q <= ex_q;
                if (id_ex_flush) begin
                    ex_q     <= '0;
                    ex_rs1_q <= '0;
                    ex_rs2_q <= '0;
                end else begin
                    ex_q     <= id_stage;
                    ex_rs1_q <= id_rs1;
                    ex_rs2_q <= id_rs2;
                end
            end
        end
    end

    assign mem_err      = (state_q == ERR);
    assign stall_cycles = stall_cnt_q;

endmodule
